mix_col_seq: RTL and testbench

Iterative AES encryption MixColumns engine: the forward counterpart of the decryption inverse-mix-column stage. It multiplies each 32-bit state column by the fixed GF(2^8) matrix {02 03 01 01 / 01 02 03 01 / 01 01 02 03 / 03 01 01 02}, one column per clock, behind a start/done handshake. It sits in the encryption datapath between ShiftRows and AddRoundKey, and is bypassed in the final round (round 10).

---
 rtl/mix_col_seq.sv | 110 +++++++++++
 tb/tb_mix_col_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mix_col_seq.sv
// Iterative AES MixColumns: one 32-bit column per clock through a single shared
// column mixer, with a start/done handshake and a final-round bypass.
module mix_col_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   round,
    input  logic [127:0] data_in,
    output logic [127:0] data_out,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_reg;
    logic [127:0] in_buf_reg;
    logic [127:0] work_reg;
    logic [127:0] work_next;
    logic [1:0]   col_idx_reg;

    logic [31:0]  in_col [4];
    logic [31:0]  sel_col;
    logic [31:0]  mix_col;
    logic [7:0]   a0, a1, a2, a3;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    // Column split of the held input and the column-replace view of work
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign in_col[gi] = in_buf_reg[gi*32 +: 32];
            assign work_next[gi*32 +: 32] = (col_idx_reg == 2'(gi)) ? mix_col
                                                                    : work_reg[gi*32 +: 32];
        end
    endgenerate

    assign sel_col = in_col[col_idx_reg];
    assign a0 = sel_col[31:24];
    assign a1 = sel_col[23:16];
    assign a2 = sel_col[15:8];
    assign a3 = sel_col[7:0];

    assign mix_col = {xtime(a0) ^ mul3(a1)  ^ a2        ^ a3,
                      a0        ^ xtime(a1) ^ mul3(a2)  ^ a3,
                      a0        ^ a1        ^ xtime(a2) ^ mul3(a3),
                      mul3(a0)  ^ a1        ^ a2        ^ xtime(a3)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            in_buf_reg  <= '0;
            work_reg    <= '0;
            col_idx_reg <= 2'd0;
            data_out    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (round == 4'd10) begin
                            data_out  <= data_in;
                            done      <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            in_buf_reg  <= data_in;
                            col_idx_reg <= 2'd0;
                            state_reg   <= CALC;
                        end
                    end
                end
                CALC: begin
                    work_reg    <= work_next;
                    col_idx_reg <= col_idx_reg + 2'd1;
                    // Last column: publish the full result straight from work_next
                    if (col_idx_reg == 2'd3) begin
                        data_out  <= work_next;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_col_seq.sv
// Bench for mix_col_seq: a cycle-level reference model driven from the same
// inputs, checked every cycle, plus directed cases with hand-computed results.
module tb_mix_col_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   round = 4'd1;
    logic [127:0] data_in = '0;
    logic [127:0] data_out;
    logic         busy;
    logic         done;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mix_col_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .round    (round),
        .data_in  (data_in),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Generic GF(2^8) shift-and-add multiply
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int n = 0; n < 8; n++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    // Circulant matrix: row i, column j uses coefficient index (j - i) mod 4 of {2,3,1,1}
    function automatic logic [7:0] coef(input int d);
        case (d)
            0: return 8'd2;
            1: return 8'd3;
            default: return 8'd1;
        endcase
    endfunction

    function automatic logic [127:0] mix128(input logic [127:0] s);
        logic [127:0] r = '0;
        logic [31:0]  c;
        logic [7:0]   acc;
        for (int k = 0; k < 4; k++) begin
            c = s[k*32 +: 32];
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(c[31-8*j -: 8], coef((j - i + 4) % 4));
                r[k*32 + 31 - 8*i -: 8] = acc;
            end
        end
        return r;
    endfunction

    // Reference timing: cycles of busy remaining after each edge; the last busy cycle is done
    int           m_cnt = 0;
    int           n_acc = 0;
    logic [127:0] m_pend = '0;
    logic [127:0] exp_out = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt   = 0;
            m_pend  = '0;
            exp_out = '0;
        end else begin
            if (m_cnt == 0) begin
                if (start) begin
                    n_acc++;
                    if (round == 4'd10) begin
                        m_cnt  = 1;
                        m_pend = data_in;
                    end else begin
                        m_cnt  = 5;
                        m_pend = mix128(data_in);
                    end
                end
            end else begin
                m_cnt--;
            end
            if (m_cnt == 1) exp_out = m_pend;
        end
    end

    always @(negedge clk) begin
        check("busy", 128'(busy), 128'(m_cnt != 0));
        check("done", 128'(done), 128'(m_cnt == 1));
        check("data_out", data_out, exp_out);
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic s, input logic [3:0] r, input logic [127:0] d);
        start   = s;
        round   = r;
        data_in = d;
    endtask

    localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] FIX_IN   = 128'hc6c6c6c6_d4d4d4d4_01010101_c6c6c6c6 | 128'h1_00000000_00000000;
    localparam logic [127:0] FIX_OUT  = 128'hc6c6c6c6_d5d5d7d6_01010101_c6c6c6c6;
    localparam logic [127:0] BYP_IN   = 128'h00112233_44556677_8899aabb_ccddeeff;

    initial begin
        int lat;
        int guard;

        tick;
        tick;
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_done", 128'(done), 128'd0);
        check("reset_data", data_out, 128'd0);
        rst = 1'b0;
        tick;

        // FIPS-197 column vector with latency measurement
        set_in(1'b1, 4'd1, FIPS_IN);
        tick;
        set_in(1'b0, 4'd1, '0);
        lat = 0;
        for (int n = 1; n <= 8 && lat == 0; n++) begin
            tick;
            if (done) lat = n;
        end
        check("fips_latency", 128'(lat), 128'd4);
        check("fips_data", data_out, FIPS_OUT);
        tick;

        // Fixed-point columns
        set_in(1'b1, 4'd5, FIX_IN);
        tick;
        set_in(1'b0, 4'd5, '0);
        for (int n = 0; n < 4; n++) tick;
        check("fixed_done", 128'(done), 128'd1);
        check("fixed_data", data_out, FIX_OUT);
        tick;

        // Final-round bypass
        set_in(1'b1, 4'd10, BYP_IN);
        tick;
        set_in(1'b0, 4'd1, '0);
        check("bypass_done", 128'(done), 128'd1);
        check("bypass_busy", 128'(busy), 128'd1);
        check("bypass_data", data_out, BYP_IN);
        tick;
        check("bypass_busy_end", 128'(busy), 128'd0);
        tick;

        // Starts during CALC and DONE are ignored; next IDLE start is taken
        set_in(1'b1, 4'd1, FIPS_IN);
        tick;
        set_in(1'b0, 4'd1, '0);
        tick;
        set_in(1'b1, 4'd10, BYP_IN);
        tick;
        set_in(1'b0, 4'd10, BYP_IN);
        tick;
        tick;
        check("prot_done", 128'(done), 128'd1);
        check("prot_data", data_out, FIPS_OUT);
        set_in(1'b1, 4'd10, ~BYP_IN);
        tick;
        check("prot_idle_busy", 128'(busy), 128'd0);
        check("prot_idle_data", data_out, FIPS_OUT);
        set_in(1'b1, 4'd10, ~FIPS_IN);
        tick;
        set_in(1'b0, 4'd1, '0);
        check("prot_restart_done", 128'(done), 128'd1);
        check("prot_restart_data", data_out, ~FIPS_IN);
        tick;

        // Reset after column 1 has been written
        set_in(1'b1, 4'd3, FIX_IN);
        tick;
        set_in(1'b0, 4'd3, '0);
        tick;
        tick;
        #1 rst = 1'b1;
        #1;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_data", data_out, 128'd0);
        tick;
        tick;
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick;
            check("rst_no_done", 128'(done), 128'd0);
        end
        set_in(1'b1, 4'd1, FIPS_IN);
        tick;
        set_in(1'b0, 4'd1, '0);
        for (int n = 0; n < 4; n++) tick;
        check("post_rst_data", data_out, FIPS_OUT);
        tick;

        // Random regression: random gaps, data and round in 1..10
        n_acc = 0;
        guard = 0;
        while (n_acc < 1000 && guard < 20000) begin
            set_in(($urandom % 4) != 0, 4'($urandom_range(1, 10)),
                   {$urandom, $urandom, $urandom, $urandom});
            tick;
            guard++;
        end
        check("random_ops_complete", 128'(n_acc >= 1000), 128'd1);
        set_in(1'b0, 4'd1, '0);
        for (int n = 0; n < 8; n++) tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
